// File: rtl/intf_array_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst-locked arbiter.
package intf_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int TO_W  = 8;
  localparam int MAX_N = 16;

  typedef struct packed {
    logic [3:0] idx;
    logic       found;
  } rr_pick_t;

  // First set bit of e, searching ptr+1, ptr+2, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] e,
                                       input int ptr, input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int k = n; k >= 1; k--) begin
      j = (ptr + k) % n;
      if (e[j[3:0]]) begin
        r.idx   = j[3:0];
        r.found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intf_array_arbiter_if.sv
// Requester/sink bus of the arbiter: N source slots in, one sink out.
// Handshake: a beat moves on a rising edge where valid and ready are both 1;
// valid never waits on ready, and ready may depend combinationally on valid.
interface intf_array_arbiter_if #(
  parameter int N      = 6,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(N)
);
  logic [N-1:0]        req_valid;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [IDX_W-1:0]    out_src;
  logic                out_ready;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/intf_array_arbiter_rr_pick_n.sv
// Rotating priority encoder: first set bit of e after position ptr, wrapping.
module rr_pick_n #(
  parameter int N     = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     e,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin : pick
    int j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    // Walk from farthest to nearest so the nearest hit is written last.
    for (int k = N; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (e[j[IDX_W-1:0]]) begin
        idx   = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intf_array_arbiter.sv
// Round-robin, burst-locked arbiter with enable mask and idle watchdog.
module intf_array_arbiter
  import intf_arb_pkg::*;
#(
  parameter int N       = 6,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = $clog2(N),
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  intf_array_arbiter_if.slave   bus,
  input  logic                  cfg_we,
  input  logic [N-1:0]          cfg_mask,
  output logic                  busy,
  output logic                  timeout_err,
  output state_e                state_dbg
);

  state_e            state, state_n;
  logic [IDX_W-1:0]  grant_idx, grant_n;
  logic [IDX_W-1:0]  rr_ptr, rr_n;
  logic [N-1:0]      mask;
  logic [TO_W-1:0]   idle_cnt, cnt_n;

  logic [N-1:0]      elig;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              in_busy, g_valid, g_last, last_xfer;
  logic [DATA_W-1:0] g_data;

  assign elig    = bus.req_valid & mask;
  assign in_busy = (state == BUSY);
  assign g_valid = bus.req_valid[grant_idx];
  assign g_last  = bus.req_last[grant_idx];
  assign g_data  = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];

  rr_pick_n #(.N(N), .IDX_W(IDX_W)) u_pick (
    .e     (elig),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Forwarding is combinational from the held grant so the sink sees slot beats directly.
  always_comb begin
    bus.req_ready = '0;
    if (in_busy) bus.req_ready[grant_idx] = bus.out_ready;
    bus.out_valid = in_busy & g_valid;
    bus.out_data  = in_busy ? g_data : '0;
    bus.out_last  = in_busy & g_last;
    bus.out_src   = grant_idx;
    busy          = in_busy;
    state_dbg     = state;
    timeout_err   = in_busy & ~g_valid & (idle_cnt == TO_W'(TIMEOUT - 1));
    last_xfer     = in_busy & g_valid & bus.out_ready & g_last;
  end

  always_comb begin
    state_n = state;
    grant_n = grant_idx;
    rr_n    = rr_ptr;
    cnt_n   = idle_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_n = pick_idx;
          state_n = BUSY;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (last_xfer || timeout_err) begin
          state_n = IDLE;
          rr_n    = grant_idx;
          cnt_n   = '0;
        end else if (!g_valid) begin
          cnt_n = idle_cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDX_W'(N - 1);
      idle_cnt  <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_n;
      rr_ptr    <= rr_n;
      idle_cnt  <= cnt_n;
    end
  end

  // Mask only steers future arbitration; the live grant is never touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask <= '1;
    else if (cfg_we) mask <= cfg_mask;
  end

endmodule

// File: tb/tb_intf_array_arbiter.sv
// Bench for intf_array_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_intf_array_arbiter;
  import intf_arb_pkg::*;

  localparam int N       = 6;
  localparam int W       = 8;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   rv, rl, cfg_mask;
  logic [N*W-1:0] rd;
  logic           ordy, cfg_we;
  logic           busy, timeout_err;
  state_e         state_dbg;

  intf_array_arbiter_if #(.N(N), .DATA_W(W)) bus ();
  assign bus.req_valid = rv;
  assign bus.req_data  = rd;
  assign bus.req_last  = rl;
  assign bus.out_ready = ordy;

  intf_array_arbiter #(.N(N), .DATA_W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cfg_we      (cfg_we),
    .cfg_mask    (cfg_mask),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  bit sb_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit           m_busy;
  int           m_g, m_ptr, m_cnt;
  logic [N-1:0] m_mask;
  int           m_grants[$];
  logic [N-1:0] x_ready;
  logic [N-1:0] x_elig;
  bit           x_to;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_ptr = N - 1; m_cnt = 0; m_mask = '1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      x_ready = '0;
      if (m_busy) x_ready[m_g] = ordy;
      x_to = m_busy && !rv[m_g] && (m_cnt == TIMEOUT - 1);
      chk("busy", busy, m_busy);
      chk("state_dbg", state_dbg, m_busy);
      chk("out_valid", bus.out_valid, m_busy && rv[m_g]);
      chk("req_ready", bus.req_ready, x_ready);
      chk("timeout_err", timeout_err, x_to);
      if (m_busy) begin
        chk("out_src", bus.out_src, m_g);
        chk("out_last", bus.out_last, rl[m_g]);
        chk("out_data", bus.out_data, rd[m_g*W +: W]);
      end
      if (sb_on && bus.out_valid && ordy) begin
        if (exp_q.size() > 0) chk("sb_data", bus.out_data, exp_q.pop_front());
        else chk("sb_unexpected_beat", bus.out_data, 32'hFFFF_FFFF);
      end
      // next state from the rules
      if (!m_busy) begin
        x_elig = rv & m_mask;
        if (x_elig != 0) begin
          for (int k = 1; k <= N; k++) begin
            if (x_elig[(m_ptr + k) % N]) begin
              m_g = (m_ptr + k) % N;
              break;
            end
          end
          m_busy = 1; m_cnt = 0;
          m_grants.push_back(m_g);
        end
      end else if (rv[m_g] && ordy && rl[m_g]) begin
        m_busy = 0; m_ptr = m_g; m_cnt = 0;
      end else if (!rv[m_g]) begin
        if (x_to) begin m_busy = 0; m_ptr = m_g; m_cnt = 0; end
        else m_cnt++;
      end else begin
        m_cnt = 0;
      end
      if (cfg_we) m_mask = cfg_mask;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_slot(input int i, input logic v, input logic [W-1:0] d, input logic l);
    rv[i] = v; rd[i*W +: W] = d; rl[i] = l;
  endtask

  task automatic do_reset();
    rv = '0; rl = '0; cfg_we = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  int exp_rr[7] = '{0, 1, 2, 3, 4, 5, 0};
  int exp_mk[6] = '{0, 2, 0, 2, 0, 2};
  int p;

  initial begin
    rv = '0; rl = '0; rd = '0; ordy = 1'b1; cfg_we = 1'b0; cfg_mask = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_req_ready", bus.req_ready, 0);
    chk("init_state", state_dbg, IDLE);
    rst_n = 1'b1;
    step();

    // single requester, 3-beat burst
    sb_on = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    set_slot(2, 1, 8'h11, 0);
    step(); #1;
    chk("t1_busy", busy, 1);
    chk("t1_src", bus.out_src, 2);
    chk("t1_d0", bus.out_data, 8'h11);
    step(); set_slot(2, 1, 8'h22, 0); #1;
    chk("t1_d1", bus.out_data, 8'h22);
    step(); set_slot(2, 1, 8'h33, 1); #1;
    chk("t1_d2", bus.out_data, 8'h33);
    chk("t1_last", bus.out_last, 1);
    step(); set_slot(2, 0, 8'h00, 0); #1;
    chk("t1_busy_drop", busy, 0);
    sb_on = 1'b0;

    // all slots, 1-beat bursts, fresh pointer
    do_reset();
    rv = '1; rl = '1;
    for (int i = 0; i < N; i++) rd[i*W +: W] = W'(i);
    m_grants.delete();
    for (int k = 1; k <= 14; k++) begin
      step(); #1;
      chk("t2_busy_pattern", busy, k % 2);
    end
    rv = '0; rl = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < m_grants.size()) chk("t2_rr_order", m_grants[i], exp_rr[i]);
      else chk("t2_rr_missing", i, 32'hFFFF);
    end

    // backpressure on slot 4
    step();
    sb_on = 1'b1;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    set_slot(4, 1, 8'hA1, 0);
    step(); #1;
    chk("t3_src", bus.out_src, 4);
    step(); set_slot(4, 1, 8'hA2, 1); ordy = 1'b0; #1;
    for (int k = 0; k < 20; k++) begin
      chk("t3_hold_data", bus.out_data, 8'hA2);
      chk("t3_ready_low", bus.req_ready, 0);
      chk("t3_no_timeout", timeout_err, 0);
      step();
    end
    ordy = 1'b1; #1;
    chk("t3_ready_mirror", bus.req_ready, 6'b010000);
    step(); set_slot(4, 0, 8'h00, 0);

    // watchdog on slot 1, slot 2 waiting
    step();
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    set_slot(1, 1, 8'h55, 0);
    step(); #1;
    chk("t4_src", bus.out_src, 1);
    set_slot(2, 1, 8'h66, 1);
    step(); set_slot(1, 0, 8'h00, 0); #1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      chk("t4_timeout_timing", timeout_err, cyc == 15);
      if (cyc < 15) step();
    end
    step(); #1;
    chk("t4_back_idle", busy, 0);
    step(); #1;
    chk("t4_next_busy", busy, 1);
    chk("t4_next_src", bus.out_src, 2);
    step(); set_slot(2, 0, 8'h00, 0);
    step();
    chk("t4_sb_drain", exp_q.size(), 0);
    sb_on = 1'b0;

    // mask change during a slot-3 burst
    for (int i = 0; i < N; i++) set_slot(i, 1, W'(i), 1);
    set_slot(3, 1, 8'h30, 0);
    step(); #1;
    chk("t5_src", bus.out_src, 3);
    cfg_we = 1'b1; cfg_mask = 6'b000101;
    step(); cfg_we = 1'b0; set_slot(3, 1, 8'h31, 0); #1;
    chk("t5_still_busy", busy, 1);
    step(); set_slot(3, 1, 8'h32, 1);
    m_grants.delete();
    step();
    repeat (12) step();
    for (int i = 0; i < 6; i++) begin
      if (i < m_grants.size()) chk("t5_mask_order", m_grants[i], exp_mk[i]);
      else chk("t5_mask_missing", i, 32'hFFFF);
    end

    // async reset mid-burst
    p = 0;
    while (!busy && p < 8) begin step(); p++; end
    chk("t6_reached_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_ready", bus.req_ready, 0);
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_busy", busy, 0);
    step(); step();
    rst_n = 1'b1;
    step(); #1;
    chk("t6_first_src", bus.out_src, 0);
    chk("t6_first_busy", busy, 1);

    // random traffic at several request densities
    for (int seg = 0; seg < 3; seg++) begin
      p = (seg == 0) ? 80 : (seg == 1) ? 40 : 10;
      repeat (1000) begin
        step();
        for (int i = 0; i < N; i++) begin
          rv[i] = ($urandom_range(99) < p);
          rl[i] = ($urandom_range(99) < 30);
          rd[i*W +: W] = W'($urandom_range(255));
        end
        ordy     = ($urandom_range(99) < 75);
        cfg_we   = ($urandom_range(99) < 3);
        cfg_mask = N'($urandom_range((1 << N) - 1));
      end
    end
    step();
    rv = '0; cfg_we = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
